// File: rtl/sad_min_search.sv
// Running-minimum tracker for one full-search motion-estimation pass.
// Accepts one SAD per candidate in raster order and reports the best vector with a done pulse.
module sad_min_search #(
  parameter int SAD_W = 16,
  parameter int RANGE = 8,
  parameter int MV_W  = 5,
  localparam int CNT_W = 2 * $clog2(2 * RANGE) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sad_valid,
  input  logic [SAD_W-1:0]        sad,
  output logic                    busy,
  output logic                    done,
  output logic [SAD_W-1:0]        best_sad,
  output logic signed [MV_W-1:0]  best_mvx,
  output logic signed [MV_W-1:0]  best_mvy,
  output logic [CNT_W-1:0]        cand_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_DONE
  } state_e;

  localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-RANGE);
  localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(RANGE - 1);

  state_e                   r_state;
  state_e                   w_next_state;
  logic                     w_busy;
  logic                     w_done;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_take;
  logic                     r_first;
  logic signed [MV_W-1:0]   r_x;
  logic signed [MV_W-1:0]   r_y;
  logic [SAD_W-1:0]         r_best_sad;
  logic signed [MV_W-1:0]   r_best_mvx;
  logic signed [MV_W-1:0]   r_best_mvy;
  logic [CNT_W-1:0]         r_cand_cnt;

  // start outranks a same-cycle sad_valid, so acceptance is gated by it.
  assign w_accept = (r_state == S_SEARCH) && sad_valid && !start;
  assign w_last   = w_accept && (r_x == MV_MAX) && (r_y == MV_MAX);
  assign w_take   = r_first || (sad < r_best_sad);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: each combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next_state = S_SEARCH;
      S_SEARCH: begin
        if (start)       w_next_state = S_SEARCH;
        else if (w_last) w_next_state = S_DONE;
      end
      S_DONE:   w_next_state = start ? S_SEARCH : S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_SEARCH: w_busy = 1'b1;
      S_DONE:   w_done = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_first    <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_best_sad <= '0;
      r_best_mvx <= '0;
      r_best_mvy <= '0;
      r_cand_cnt <= '0;
    end else if (start) begin
      // best_* are left untouched: r_first forces the next acceptance to overwrite them.
      r_first    <= 1'b1;
      r_x        <= MV_MIN;
      r_y        <= MV_MIN;
      r_cand_cnt <= '0;
    end else if (w_accept) begin
      r_first    <= 1'b0;
      r_cand_cnt <= r_cand_cnt + CNT_W'(1);
      if (r_x == MV_MAX) begin
        r_x <= MV_MIN;
        r_y <= r_y + MV_W'(1);
      end else begin
        r_x <= r_x + MV_W'(1);
      end
      if (w_take) begin
        r_best_sad <= sad;
        r_best_mvx <= r_x;
        r_best_mvy <= r_y;
      end
    end
  end

  assign busy     = w_busy;
  assign done     = w_done;
  assign best_sad = r_best_sad;
  assign best_mvx = r_best_mvx;
  assign best_mvy = r_best_mvy;
  assign cand_cnt = r_cand_cnt;

endmodule

// File: tb/tb_sad_min_search.sv
// Bench for sad_min_search: table-driven searches, randomized searches against a
// brute-force minimum model, and abort/reset sequences.
module tb_sad_min_search;

  localparam int SAD_W = 16;
  localparam int RANGE = 8;
  localparam int MV_W  = 5;
  localparam int SIDE  = 2 * RANGE;
  localparam int NCAND = SIDE * SIDE;
  localparam int CNT_W = 2 * $clog2(SIDE) + 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start;
  logic                   sad_valid;
  logic [SAD_W-1:0]       sad;
  logic                   busy;
  logic                   done;
  logic [SAD_W-1:0]       best_sad;
  logic signed [MV_W-1:0] best_mvx;
  logic signed [MV_W-1:0] best_mvy;
  logic [CNT_W-1:0]       cand_cnt;

  sad_min_search #(.SAD_W(SAD_W), .RANGE(RANGE), .MV_W(MV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sad_valid (sad_valid),
    .sad       (sad),
    .busy      (busy),
    .done      (done),
    .best_sad  (best_sad),
    .best_mvx  (best_mvx),
    .best_mvy  (best_mvy),
    .cand_cnt  (cand_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    pattern;   // 0 descending, 1 single minimum, 2 flat 300, 3 flat 0xFFFF
    int    gap_pct;
    int    exp_sad;
    int    exp_x;
    int    exp_y;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   sads[NCAND];
  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Brute-force minimum over the first n candidates; strict < keeps the earliest on ties.
  task automatic ref_best(input int n, output int s, output int x, output int y);
    int kb = 0;
    for (int k = 1; k < n; k++) if (sads[k] < sads[kb]) kb = k;
    s = sads[kb];
    x = (kb % SIDE) - RANGE;
    y = (kb / SIDE) - RANGE;
  endtask

  task automatic fill(input int pattern);
    for (int k = 0; k < NCAND; k++) begin
      case (pattern)
        0:       sads[k] = 1000 - k;
        1:       sads[k] = (k == 137) ? 12 : 500;
        2:       sads[k] = 300;
        default: sads[k] = 16'hFFFF;
      endcase
    end
  endtask

  task automatic begin_search(input string name, input logic valid_too);
    start     = 1'b1;
    sad_valid = valid_too;
    sad       = 16'd1;
    step();
    start     = 1'b0;
    sad_valid = 1'b0;
    check({name, " start cand_cnt"}, int'(cand_cnt), 0);
    check({name, " start busy"}, int'(busy), 1);
  endtask

  // Feeds candidates until `upto` are accepted, checking counters and the running minimum each cycle.
  task automatic feed(input string name, input int upto, input int gap_pct);
    int acc    = int'(cand_cnt);
    int budget = 20 * NCAND;
    int es, ex, ey;
    while (acc < upto && budget > 0) begin
      sad_valid = ($urandom_range(99) >= gap_pct);
      sad       = SAD_W'(sads[acc]);
      step();
      budget--;
      if (sad_valid) acc++;
      sad_valid = 1'b0;
      if (acc < NCAND) begin
        check({name, " busy"}, int'(busy), 1);
        check({name, " done early"}, int'(done), 0);
      end
      check({name, " cand_cnt"}, int'(cand_cnt), acc);
      if (acc > 0) begin
        ref_best(acc, es, ex, ey);
        check({name, " run sad"}, int'(best_sad), es);
        check({name, " run mvx"}, int'(best_mvx), ex);
        check({name, " run mvy"}, int'(best_mvy), ey);
      end
    end
    if (budget == 0) check({name, " feed timeout"}, acc, upto);
  endtask

  task automatic finish_check(input string name, input int es, input int ex, input int ey);
    check({name, " done"}, int'(done), 1);
    check({name, " busy in done"}, int'(busy), 0);
    check({name, " final cnt"}, int'(cand_cnt), NCAND);
    check({name, " final sad"}, int'(best_sad), es);
    check({name, " final mvx"}, int'(best_mvx), ex);
    check({name, " final mvy"}, int'(best_mvy), ey);
    // Valids with a tiny SAD in DONE and then IDLE must be ignored.
    for (int c = 0; c < 3; c++) begin
      sad_valid = 1'b1;
      sad       = 16'd1;
      step();
      check({name, " done pulse"}, int'(done), 0);
      check({name, " idle busy"}, int'(busy), 0);
      check({name, " hold sad"}, int'(best_sad), es);
      check({name, " hold mvx"}, int'(best_mvx), ex);
      check({name, " hold mvy"}, int'(best_mvy), ey);
      check({name, " hold cnt"}, int'(cand_cnt), NCAND);
    end
    sad_valid = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check({name, " busy"}, int'(busy), 0);
    check({name, " done"}, int'(done), 0);
    check({name, " best_sad"}, int'(best_sad), 0);
    check({name, " best_mvx"}, int'(best_mvx), 0);
    check({name, " best_mvy"}, int'(best_mvy), 0);
    check({name, " cand_cnt"}, int'(cand_cnt), 0);
  endtask

  initial begin
    int es, ex, ey;

    vecs[0] = '{"descending",  0,  0,   745,  7,  7};
    vecs[1] = '{"single_min",  1,  0,    12,  1,  0};
    vecs[2] = '{"single_gaps", 1, 50,    12,  1,  0};
    vecs[3] = '{"ties_300",    2,  0,   300, -8, -8};
    vecs[4] = '{"max_ffff",    3, 20, 65535, -8, -8};

    rst_n     = 1'b0;
    start     = 1'b1;
    sad_valid = 1'b1;
    sad       = 16'd7;
    step();
    step();
    check_zero("reset");
    rst_n     = 1'b1;
    start     = 1'b0;
    sad_valid = 1'b0;
    step();
    check_zero("post reset idle");

    foreach (vecs[i]) begin
      fill(vecs[i].pattern);
      begin_search(vecs[i].name, 1'b0);
      feed(vecs[i].name, NCAND, vecs[i].gap_pct);
      finish_check(vecs[i].name, vecs[i].exp_sad, vecs[i].exp_x, vecs[i].exp_y);
    end

    // Randomized searches; a narrow SAD range forces frequent ties.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NCAND; k++)
        sads[k] = (r < 2) ? int'($urandom_range(65535)) : int'($urandom_range(40));
      ref_best(NCAND, es, ex, ey);
      begin_search("random", 1'b0);
      feed("random", NCAND, 30 * (r % 2));
      finish_check("random", es, ex, ey);
    end

    // Abort after 100 candidates with minimum 5 at k=40, then restart.
    for (int k = 0; k < NCAND; k++) sads[k] = 600;
    sads[40] = 5;
    begin_search("abort_a", 1'b0);
    feed("abort_a", 100, 0);
    check("abort_a min", int'(best_sad), 5);
    check("abort_a mvy", int'(best_mvy), -6);
    begin_search("abort_restart", 1'b1);
    for (int k = 0; k < NCAND; k++) sads[k] = 900;
    sads[3] = 50;
    feed("abort_b", NCAND, 25);
    finish_check("abort_b", 50, -5, -8);

    // Synchronous reset in the middle of a search.
    fill(1);
    begin_search("midreset", 1'b0);
    feed("midreset", 200, 0);
    rst_n     = 1'b0;
    sad_valid = 1'b1;
    sad       = 16'd3;
    step();
    check_zero("midreset");
    rst_n     = 1'b1;
    sad_valid = 1'b1;
    step();
    check_zero("midreset idle");
    sad_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
